scramble_pack: RTL and testbench

SCRAMBLE_PACK -- requirements
Module: scramble_pack

---
 rtl/scramble_pack_pkg.sv | 17 +
 rtl/scramble_pack_scrambler_byte.sv | 26 ++
 rtl/scramble_pack.sv | 111 +++++++++++
 tb/tb_scramble_pack.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/scramble_pack_pkg.sv
// Shared constants for the byte scrambler / word packer slice.
// Holds the LFSR taps, default seed and output word geometry.
package scramble_pack_pkg;

    localparam int unsigned LFSR_W         = 7;
    localparam int unsigned TAP_HI         = 6;
    localparam int unsigned TAP_LO         = 3;
    localparam logic [6:0]  DEFAULT_SEED   = 7'h7F;
    localparam int unsigned WORD_W         = 32;
    localparam logic [2:0]  CNT_FULL       = 3'd4;

    // An all-zero LFSR state would lock up, so it is replaced by the default.
    function automatic logic [6:0] fix_seed(input logic [6:0] s);
        return (s == 7'h00) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/scramble_pack_scrambler_byte.sv
// Combinational 8-bit step of the additive scrambler, LSB first.
module scrambler_byte
    import scramble_pack_pkg::*;
(
    input  logic [LFSR_W-1:0] st_in,
    input  logic [7:0]        byte_in,
    output logic [7:0]        byte_out,
    output logic [LFSR_W-1:0] st_out
);

    // Unrolled bit-serial LFSR: eight shifts per clock.
    always_comb begin : step_comb
        logic [LFSR_W-1:0] st_v;
        logic              s_v;
        st_v     = st_in;
        s_v      = 1'b0;
        byte_out = 8'h00;
        for (int i = 0; i < 8; i++) begin
            s_v              = st_v[TAP_HI] ^ st_v[TAP_LO];
            byte_out[i[2:0]] = byte_in[i[2:0]] ^ s_v;
            st_v             = {st_v[LFSR_W-2:0], s_v};
        end
        st_out = st_v;
    end

endmodule

// File: rtl/scramble_pack.sv
// Scrambles an upstream byte stream and packs it little-endian into
// 32-bit words held in an output register until the consumer acks.
module scramble_pack
    import scramble_pack_pkg::*;
#(
    parameter logic [6:0] SEED_RST = DEFAULT_SEED
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              seed_load,
    input  logic [6:0]        seed,
    input  logic              flush,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o,
    input  logic              ack_o
);

    logic [6:0]        st_r;
    logic [WORD_W-1:0] pack_r;
    logic [2:0]        pack_cnt_r;
    logic              padding_r;
    logic              valid_r;
    logic              ready_r;
    logic [WORD_W-1:0] data_r;

    logic              accept_s;
    logic              pad_ins_s;
    logic              drain_s;
    logic [6:0]        st_cur_s;
    logic [7:0]        byte_in_s;
    logic [7:0]        byte_scr_s;
    logic [6:0]        st_step_s;
    logic [6:0]        st_nxt_s;
    logic [WORD_W-1:0] pack_nxt_s;
    logic [2:0]        cnt_nxt_s;
    logic              pad_nxt_s;

    assign accept_s  = byte_valid && ready_r;
    assign pad_ins_s = padding_r && (pack_cnt_r != CNT_FULL);
    assign drain_s   = (pack_cnt_r == CNT_FULL) && (!valid_r || ack_o);
    // A seed load replaces the state before any byte of this cycle is scrambled.
    assign st_cur_s  = seed_load ? fix_seed(seed) : st_r;
    assign byte_in_s = padding_r ? 8'h00 : byte_data;

    scrambler_byte u_scrambler_byte (
        .st_in    (st_cur_s),
        .byte_in  (byte_in_s),
        .byte_out (byte_scr_s),
        .st_out   (st_step_s)
    );

    // Next-state of scrambler, packer and padding flag.
    always_comb begin
        st_nxt_s   = st_cur_s;
        pack_nxt_s = pack_r;
        cnt_nxt_s  = pack_cnt_r;
        pad_nxt_s  = padding_r;
        if (drain_s) begin
            cnt_nxt_s = 3'd0;
        end else if (accept_s || pad_ins_s) begin
            st_nxt_s = st_step_s;
            pack_nxt_s[{pack_cnt_r[1:0], 3'b000} +: 8] = byte_scr_s;
            cnt_nxt_s = pack_cnt_r + 3'd1;
        end else begin
            cnt_nxt_s = pack_cnt_r;
        end
        // Flush looks at the count after this cycle's byte has been packed.
        if (padding_r) begin
            pad_nxt_s = (cnt_nxt_s != CNT_FULL);
        end else if (flush && (cnt_nxt_s != 3'd0) && (cnt_nxt_s != CNT_FULL)) begin
            pad_nxt_s = 1'b1;
        end else begin
            pad_nxt_s = 1'b0;
        end
    end

    // State, packer and output register update.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            st_r       <= SEED_RST;
            pack_r     <= {WORD_W{1'b0}};
            pack_cnt_r <= 3'd0;
            padding_r  <= 1'b0;
            valid_r    <= 1'b0;
            data_r     <= {WORD_W{1'b0}};
            ready_r    <= 1'b0;
        end else begin
            st_r       <= st_nxt_s;
            pack_r     <= pack_nxt_s;
            pack_cnt_r <= cnt_nxt_s;
            padding_r  <= pad_nxt_s;
            ready_r    <= (cnt_nxt_s != CNT_FULL) && !pad_nxt_s;
            if (drain_s) begin
                data_r  <= pack_r;
                valid_r <= 1'b1;
            end else if (valid_r && ack_o) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign byte_ready = ready_r;
    assign valid_o    = valid_r;
    assign data_o     = data_r;

endmodule

// File: tb/tb_scramble_pack.sv
// Self-checking bench for scramble_pack: directed scenarios plus a random
// stream compared against a queue-based scrambler/packer reference model.
module tb_scramble_pack;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        seed_load = 1'b0;
    logic [6:0]  seed = 7'h00;
    logic        flush = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ack_o = 1'b0;

    int checks = 0;
    int passes = 0;
    int n_acc  = 0;

    logic [6:0]  m_st;
    logic [7:0]  m_part[$];
    logic [31:0] m_words[$];
    logic [31:0] got_q[$];

    scramble_pack #(.SEED_RST(7'h7F)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .seed_load  (seed_load),
        .seed       (seed),
        .flush      (flush),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ack_o      (ack_o)
    );

    always #5 CLK = ~CLK;

    // Reference: scramble one byte with integer arithmetic and pack it.
    task automatic m_accept(input logic [7:0] b);
        logic [7:0] o;
        int st;
        int s;
        st = int'(m_st);
        for (int i = 0; i < 8; i++) begin
            s = ((st >> 6) & 1) ^ ((st >> 3) & 1);
            o[i] = b[i] ^ s[0];
            st = (st * 2 + s) % 128;
        end
        m_st = st[6:0];
        m_part.push_back(o);
        if (m_part.size() == 4) begin
            m_words.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
            m_part.delete();
        end
    endtask

    task automatic m_flush();
        if (m_part.size() != 0) repeat (4 - m_part.size()) m_accept(8'h00);
    endtask

    // One clock: update the model from the inputs the DUT sees, record taken words.
    task automatic step();
        logic acc;
        acc = byte_valid && byte_ready;
        if (valid_o && ack_o) got_q.push_back(data_o);
        if (seed_load) m_st = (seed == 7'h00) ? 7'h7F : seed;
        if (acc) m_accept(byte_data);
        if (flush) m_flush();
        @(posedge CLK);
        #1;
        if (acc) n_acc++;
    endtask

    task automatic do_reset();
        RST = 1'b0; seed_load = 1'b0; flush = 1'b0; byte_valid = 1'b0;
        byte_data = 8'h00; ack_o = 1'b0; seed = 7'h00;
        m_st = 7'h7F; m_part.delete(); m_words.delete(); got_q.delete(); n_acc = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else passes++;
        checks++; if (data_o !== 32'h0) $display("FAIL reset_data: got %h want 00000000", data_o); else passes++;
        checks++; if (byte_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", byte_ready); else passes++;
        do_reset();
        checks++; if (byte_ready !== 1'b1) $display("FAIL reset_ready_rise: got %b want 1", byte_ready); else passes++;
    endtask

    task automatic test_basic();
        do_reset();
        byte_valid = 1'b1; byte_data = 8'h00;
        repeat (4) step();
        byte_valid = 1'b0;
        checks++; if (valid_o !== 1'b0) $display("FAIL basic_latency: got valid %b want 0", valid_o); else passes++;
        checks++; if (byte_ready !== 1'b0) $display("FAIL basic_full_ready: got %b want 0", byte_ready); else passes++;
        step();
        checks++; if (valid_o !== 1'b1) $display("FAIL basic_valid: got %b want 1", valid_o); else passes++;
        checks++; if (data_o !== 32'h40934F70) $display("FAIL basic_word: got %h want 40934f70", data_o); else passes++;
        checks++; if (m_words.size() != 1 || data_o !== m_words[0]) $display("FAIL basic_model: got %h model words %0d", data_o, m_words.size()); else passes++;
        repeat (5) step();
        checks++; if (valid_o !== 1'b1 || data_o !== 32'h40934F70) $display("FAIL basic_hold: got valid %b data %h want 1 40934f70", valid_o, data_o); else passes++;
        ack_o = 1'b1; step(); ack_o = 1'b0;
        checks++; if (valid_o !== 1'b0) $display("FAIL basic_ack_clear: got %b want 0", valid_o); else passes++;
        ack_o = 1'b1; step(); ack_o = 1'b0;
        checks++; if (valid_o !== 1'b0 || got_q.size() != 1) $display("FAIL basic_idle_ack: got valid %b taken %0d want 0 1", valid_o, got_q.size()); else passes++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        byte_valid = 1'b1; byte_data = 8'h00;
        repeat (12) step();
        checks++; if (n_acc != 8) $display("FAIL bp_accepted: got %0d want 8", n_acc); else passes++;
        checks++; if (byte_ready !== 1'b0 || valid_o !== 1'b1) $display("FAIL bp_stall: got ready %b valid %b want 0 1", byte_ready, valid_o); else passes++;
        ack_o = 1'b1; step(); ack_o = 1'b0;
        checks++; if (valid_o !== 1'b1 || m_words.size() < 2 || data_o !== m_words[1]) $display("FAIL bp_next_word: got valid %b data %h", valid_o, data_o); else passes++;
        for (int c = 0; c < 40 && n_acc < 12; c++) step();
        byte_valid = 1'b0;
        ack_o = 1'b1;
        for (int c = 0; c < 40 && got_q.size() < 3; c++) step();
        ack_o = 1'b0;
        checks++; if (got_q.size() != 3 || m_words.size() != 3) $display("FAIL bp_count: got %0d words model %0d want 3", got_q.size(), m_words.size()); else passes++;
        for (int i = 0; i < got_q.size() && i < m_words.size(); i++) begin
            checks++; if (got_q[i] !== m_words[i]) $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], m_words[i]); else passes++;
        end
    endtask

    task automatic test_flush();
        do_reset();
        byte_valid = 1'b1; byte_data = 8'hFF;
        repeat (2) step();
        byte_valid = 1'b0; flush = 1'b1; step(); flush = 1'b0;
        checks++; if (byte_ready !== 1'b0) $display("FAIL flush_pad1_ready: got %b want 0", byte_ready); else passes++;
        step();
        checks++; if (byte_ready !== 1'b0) $display("FAIL flush_pad2_ready: got %b want 0", byte_ready); else passes++;
        for (int c = 0; c < 10 && valid_o !== 1'b1; c++) step();
        checks++; if (valid_o !== 1'b1 || data_o !== 32'h4093B08F) $display("FAIL flush_word: got valid %b data %h want 1 4093b08f", valid_o, data_o); else passes++;
        checks++; if (m_words.size() != 1 || data_o !== m_words[0]) $display("FAIL flush_model: got %h model words %0d", data_o, m_words.size()); else passes++;
        checks++; if (byte_ready !== 1'b1) $display("FAIL flush_ready_back: got %b want 1", byte_ready); else passes++;
        ack_o = 1'b1; step(); ack_o = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        checks++; if (byte_ready !== 1'b1 || valid_o !== 1'b0) $display("FAIL flush_empty_noop: got ready %b valid %b want 1 0", byte_ready, valid_o); else passes++;
    endtask

    task automatic test_seed_zero();
        do_reset();
        seed_load = 1'b1; seed = 7'h15; step();
        seed = 7'h00; byte_valid = 1'b1; byte_data = 8'h00; step();
        seed_load = 1'b0;
        repeat (3) step();
        byte_valid = 1'b0;
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 32'h40934F70) $display("FAIL seed_zero_word: got valid %b data %h want 1 40934f70", valid_o, data_o); else passes++;
    endtask

    task automatic test_reset_midword();
        do_reset();
        byte_valid = 1'b1; byte_data = 8'h00;
        for (int c = 0; c < 20 && n_acc < 7; c++) step();
        byte_valid = 1'b0;
        checks++; if (valid_o !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", valid_o); else passes++;
        #2;
        RST = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || data_o !== 32'h0 || byte_ready !== 1'b0) $display("FAIL midrst_async: got valid %b data %h ready %b want 0 0 0", valid_o, data_o, byte_ready); else passes++;
        do_reset();
        byte_valid = 1'b1; byte_data = 8'h00;
        repeat (4) step();
        byte_valid = 1'b0;
        step();
        checks++; if (valid_o !== 1'b1 || data_o !== 32'h40934F70) $display("FAIL midrst_fresh_word: got valid %b data %h want 1 40934f70", valid_o, data_o); else passes++;
        ack_o = 1'b1; step(); ack_o = 1'b0;
        repeat (5) step();
        checks++; if (valid_o !== 1'b0 || got_q.size() != 1) $display("FAIL midrst_one_word: got valid %b taken %0d want 0 1", valid_o, got_q.size()); else passes++;
    endtask

    task automatic test_random_loopback();
        int cool;
        do_reset();
        cool = 0;
        for (int c = 0; c < 600; c++) begin
            byte_valid = ($urandom_range(3) != 0);
            byte_data  = 8'($urandom_range(255));
            ack_o      = ($urandom_range(2) == 0);
            flush      = ($urandom_range(15) == 0);
            seed_load  = (cool == 0) && !flush && ($urandom_range(39) == 0);
            seed       = ($urandom_range(3) == 0) ? 7'h00 : 7'($urandom_range(127));
            step();
            if (flush) cool = 6; else if (cool > 0) cool--;
        end
        byte_valid = 1'b0; seed_load = 1'b0; ack_o = 1'b0;
        flush = 1'b1; step(); flush = 1'b0;
        ack_o = 1'b1;
        for (int c = 0; c < 200 && got_q.size() < m_words.size(); c++) step();
        ack_o = 1'b0;
        checks++; if (got_q.size() != m_words.size() || m_words.size() < 20) $display("FAIL rand_count: got %0d words model %0d", got_q.size(), m_words.size()); else passes++;
        for (int i = 0; i < got_q.size() && i < m_words.size(); i++) begin
            checks++; if (got_q[i] !== m_words[i]) $display("FAIL rand_word%0d: got %h want %h", i, got_q[i], m_words[i]); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_flush();
        test_seed_zero();
        test_reset_midword();
        test_random_loopback();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
